// File: rtl/mor1kx_rf_writeback_cappuccino.sv
`default_nettype none
// ============================================================================
// Module      : mor1kx_rf_writeback_cappuccino
// Description : Register file with a post-reset clear sweep, registered
//               two-port read (1-cycle latency) and writeback bypass onto
//               both read ports, both for a newly decoded address and for a
//               held (stalled) read address.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   clock, all state on rising edge
//   rst_n          in   asynchronous active-low reset
//   rf_result_i    in   writeback data
//   wb_rf_wb_i     in   writeback enable
//   wb_rfd_adr_i   in   writeback destination address
//   padv_decode_i  in   decode advance, latches new read addresses
//   rfa_adr_i      in   operand A read address
//   rfb_adr_i      in   operand B read address
//   rfa_o          out  registered operand A
//   rfb_o          out  registered operand B
//   init_done_o    out  high once the clear sweep has finished
// ============================================================================
module mor1kx_rf_writeback_cappuccino #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_RF_ADDR_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [OPTION_OPERAND_WIDTH-1:0] rf_result_i,
  input  logic                            wb_rf_wb_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
  input  logic                            padv_decode_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i,
  input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfa_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] rfb_o,
  output logic                            init_done_o
);

  localparam int                            c_DEPTH    = 1 << OPTION_RF_ADDR_WIDTH;
  localparam logic [OPTION_RF_ADDR_WIDTH-1:0] c_CNT_LAST = '1;
  localparam logic [OPTION_RF_ADDR_WIDTH-1:0] c_CNT_ONE  = {{(OPTION_RF_ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                            r_state;
  state_t                            w_state_nxt;
  logic [OPTION_RF_ADDR_WIDTH-1:0]   r_cnt;

  // Storage has no reset: its contents come from the sweep and later writes.
  logic [OPTION_OPERAND_WIDTH-1:0]   r_mem [0:c_DEPTH-1];

  logic [OPTION_OPERAND_WIDTH-1:0]   r_rfa;
  logic [OPTION_OPERAND_WIDTH-1:0]   r_rfb;
  logic [OPTION_RF_ADDR_WIDTH-1:0]   r_rfa_adr;
  logic [OPTION_RF_ADDR_WIDTH-1:0]   r_rfb_adr;

  logic                              w_wb_valid;
  logic                              w_we;
  logic [OPTION_RF_ADDR_WIDTH-1:0]   w_wadr;
  logic [OPTION_OPERAND_WIDTH-1:0]   w_wdata;

  logic [OPTION_OPERAND_WIDTH-1:0]   w_rfa_nxt;
  logic [OPTION_OPERAND_WIDTH-1:0]   w_rfb_nxt;
  logic [OPTION_RF_ADDR_WIDTH-1:0]   w_rfa_adr_nxt;
  logic [OPTION_RF_ADDR_WIDTH-1:0]   w_rfb_adr_nxt;

  // A writeback only counts once the sweep is done; r0 is hardwired to zero,
  // so a write to it is dropped and can never bypass either.
  assign w_wb_valid = (r_state == ST_READY) && wb_rf_wb_i &&
                      (wb_rfd_adr_i != '0);

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Write port: the sweep owns it during INIT, the writeback path afterwards.
  // --------------------------------------------------------------------------
  always_comb begin
    w_we    = 1'b0;
    w_wadr  = r_cnt;
    w_wdata = '0;
    if (r_state == ST_INIT) begin
      w_we = 1'b1;
    end else if (w_wb_valid) begin
      w_we    = 1'b1;
      w_wadr  = wb_rfd_adr_i;
      w_wdata = rf_result_i;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wadr] <= w_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  always_comb begin
    w_rfa_nxt     = r_rfa;
    w_rfb_nxt     = r_rfb;
    w_rfa_adr_nxt = r_rfa_adr;
    w_rfb_adr_nxt = r_rfb_adr;

    if (r_state == ST_INIT) begin
      w_rfa_nxt     = '0;
      w_rfb_nxt     = '0;
      w_rfa_adr_nxt = '0;
      w_rfb_adr_nxt = '0;
    end else if (padv_decode_i) begin
      // New decode: the array still holds the old value of an entry being
      // written this same edge, so a matching writeback wins.
      w_rfa_adr_nxt = rfa_adr_i;
      w_rfb_adr_nxt = rfb_adr_i;

      if (rfa_adr_i == '0) begin
        w_rfa_nxt = '0;
      end else if (w_wb_valid && (rfa_adr_i == wb_rfd_adr_i)) begin
        w_rfa_nxt = rf_result_i;
      end else begin
        w_rfa_nxt = r_mem[rfa_adr_i];
      end

      if (rfb_adr_i == '0) begin
        w_rfb_nxt = '0;
      end else if (w_wb_valid && (rfb_adr_i == wb_rfd_adr_i)) begin
        w_rfb_nxt = rf_result_i;
      end else begin
        w_rfb_nxt = r_mem[rfb_adr_i];
      end
    end else begin
      // Decode stalled: keep operands fresh if their register is rewritten.
      // w_wb_valid excludes r0, so a held address of 0 never picks this up.
      if (w_wb_valid && (r_rfa_adr == wb_rfd_adr_i)) begin
        w_rfa_nxt = rf_result_i;
      end
      if (w_wb_valid && (r_rfb_adr == wb_rfd_adr_i)) begin
        w_rfb_nxt = rf_result_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rfa     <= '0;
      r_rfb     <= '0;
      r_rfa_adr <= '0;
      r_rfb_adr <= '0;
    end else begin
      r_rfa     <= w_rfa_nxt;
      r_rfb     <= w_rfb_nxt;
      r_rfa_adr <= w_rfa_adr_nxt;
      r_rfb_adr <= w_rfb_adr_nxt;
    end
  end

  assign rfa_o       = r_rfa;
  assign rfb_o       = r_rfb;
  assign init_done_o = (r_state == ST_READY);

endmodule
`default_nettype wire

// File: tb/tb_mor1kx_rf_writeback_cappuccino.sv
`default_nettype none
// ============================================================================
// Module      : tb_mor1kx_rf_writeback_cappuccino
// Description : Self-checking bench for mor1kx_rf_writeback_cappuccino.
//               Table-driven vectors fed through an expectation queue, plus
//               hand-written reset / sweep sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mor1kx_rf_writeback_cappuccino;

  logic        clk;
  logic        rst_n;
  logic [31:0] rf_result_i;
  logic        wb_rf_wb_i;
  logic [4:0]  wb_rfd_adr_i;
  logic        padv_decode_i;
  logic [4:0]  rfa_adr_i;
  logic [4:0]  rfb_adr_i;
  logic [31:0] rfa_o;
  logic [31:0] rfb_o;
  logic        init_done_o;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        wb;
    logic [4:0]  wadr;
    logic [31:0] wdata;
    logic        padv;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  vec_t vecs [14];
  exp_t sb [$];

  mor1kx_rf_writeback_cappuccino #(
    .OPTION_OPERAND_WIDTH(32),
    .OPTION_RF_ADDR_WIDTH(5)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rf_result_i   (rf_result_i),
    .wb_rf_wb_i    (wb_rf_wb_i),
    .wb_rfd_adr_i  (wb_rfd_adr_i),
    .padv_decode_i (padv_decode_i),
    .rfa_adr_i     (rfa_adr_i),
    .rfb_adr_i     (rfb_adr_i),
    .rfa_o         (rfa_o),
    .rfb_o         (rfb_o),
    .init_done_o   (init_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic wb, input logic [4:0] wadr,
                              input logic [31:0] wdata, input logic padv,
                              input logic [4:0] ra, input logic [4:0] rb,
                              input logic [31:0] ea, input logic [31:0] eb);
    vec_t v;
    v.wb = wb; v.wadr = wadr; v.wdata = wdata; v.padv = padv;
    v.ra = ra; v.rb = rb; v.exp_a = ea; v.exp_b = eb;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wb, input logic [4:0] wadr, input logic [31:0] wdata,
                       input logic padv, input logic [4:0] ra, input logic [4:0] rb);
    wb_rf_wb_i    = wb;
    wb_rfd_adr_i  = wadr;
    rf_result_i   = wdata;
    padv_decode_i = padv;
    rfa_adr_i     = ra;
    rfb_adr_i     = rb;
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input string name, input vec_t v);
    exp_t e;
    exp_t got;
    drive(v.wb, v.wadr, v.wdata, v.padv, v.ra, v.rb);
    e.a = v.exp_a;
    e.b = v.exp_b;
    sb.push_back(e);
    tick();
    got = sb.pop_front();
    check({name, " rfa"}, rfa_o, got.a);
    check({name, " rfb"}, rfb_o, got.b);
  endtask

  // Counts edges after reset release until init_done_o rises; during the
  // sweep it also tries to write/read r1 and records any non-zero operand.
  task automatic wait_init(output int cycles, output logic leak);
    cycles = 0;
    leak   = 1'b0;
    drive(1'b1, 5'd1, 32'h0000_0BAD, 1'b1, 5'd1, 5'd1);
    while (!init_done_o && cycles < 100) begin
      tick();
      cycles++;
      if (rfa_o != 32'h0 || rfb_o != 32'h0) leak = 1'b1;
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
  endtask

  initial begin
    int   cyc;
    logic leak;
    vec_t v;

    vecs[0]  = mk(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd0, 32'h0,         32'h0);
    vecs[1]  = mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);
    vecs[2]  = mk(1'b1, 5'd7, 32'h1234_5678, 1'b1, 5'd7, 5'd7, 32'h1234_5678, 32'h1234_5678);
    vecs[3]  = mk(1'b1, 5'd3, 32'h0000_0001, 1'b1, 5'd7, 5'd5, 32'h1234_5678, 32'hDEAD_BEEF);
    vecs[4]  = mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 5'd5, 32'h0000_0001, 32'hDEAD_BEEF);
    vecs[5]  = mk(1'b1, 5'd3, 32'hA5A5_A5A5, 1'b0, 5'd9, 5'd9, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    vecs[6]  = mk(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    vecs[7]  = mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 5'd3, 32'h0,         32'hA5A5_A5A5);
    vecs[8]  = mk(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 32'h0,         32'h0);
    vecs[9]  = mk(1'b1, 5'd5, 32'hCAFE_F00D, 1'b0, 5'd1, 5'd2, 32'h0,         32'h0);
    vecs[10] = mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd5, 5'd7, 32'hCAFE_F00D, 32'h1234_5678);
    vecs[11] = mk(1'b1, 5'd7, 32'h0BAD_CAFE, 1'b0, 5'd0, 5'd0, 32'hCAFE_F00D, 32'h0BAD_CAFE);
    vecs[12] = mk(1'b1, 5'd9, 32'h0000_0055, 1'b1, 5'd9, 5'd2, 32'h0000_0055, 32'h0);
    vecs[13] = mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd4, 5'd4, 32'h0000_0055, 32'h0);

    rst_n = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0);
    tick();
    tick();
    check("reset rfa", rfa_o, 32'h0);
    check("reset rfb", rfb_o, 32'h0);
    check("reset init_done", {31'h0, init_done_o}, 32'h0);

    // First sweep: exactly 32 edges, writes and decode ignored meanwhile.
    rst_n = 1'b1;
    wait_init(cyc, leak);
    check("sweep length", cyc, 32);
    check("init ignores inputs", {31'h0, leak}, 32'h0);

    for (int i = 0; i < 32; i++) begin
      v = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(31 - i), 32'h0, 32'h0);
      apply($sformatf("cleared r%0d", i), v);
    end

    for (int i = 0; i < 14; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
      check($sformatf("vec%0d init_done", i), {31'h0, init_done_o}, 32'h1);
    end

    // Asynchronous reset mid-operation, between clock edges.
    #3;
    rst_n = 1'b0;
    #1;
    check("async reset rfa", rfa_o, 32'h0);
    check("async reset rfb", rfb_o, 32'h0);
    check("async reset init_done", {31'h0, init_done_o}, 32'h0);
    tick();
    rst_n = 1'b1;

    // Begin a sweep, then reset again at sweep cycle 10.
    drive(1'b1, 5'd1, 32'h0000_0BAD, 1'b1, 5'd1, 5'd1);
    leak = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (init_done_o) leak = 1'b1;
    end
    check("mid-sweep still busy", {31'h0, leak}, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-sweep reset rfa", rfa_o, 32'h0);
    check("mid-sweep reset init_done", {31'h0, init_done_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    wait_init(cyc, leak);
    check("restarted sweep length", cyc, 32);
    check("restarted init ignores inputs", {31'h0, leak}, 32'h0);

    // Entries written before the reset must now be cleared.
    apply("post-reset r9/r5", mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd5, 32'h0, 32'h0));
    apply("post-reset r7/r3", mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd3, 32'h0, 32'h0));
    apply("post-reset write r9", mk(1'b1, 5'd9, 32'h1357_9BDF, 1'b1, 5'd9, 5'd0,
                                    32'h1357_9BDF, 32'h0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
